// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the APB register-file responder.
// Optional PSLVERR support is controlled by APB_SLAVE_PSLVERR_EN in the top.
package apb_slave_pkg;

  // Transfer sequencing states of the wait-state generator.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } apb_slv_state_e;

  // Byte offsets within the 4 KiB window (PADDR[11:0]).
  localparam logic [11:0] OFS_CTRL   = 12'h000;
  localparam logic [11:0] OFS_DATA   = 12'h004;
  localparam logic [11:0] OFS_STATUS = 12'h008;
  localparam logic [11:0] OFS_WCNT   = 12'h00C;

  // Decoded register selector; REG_NONE covers unmapped and unaligned offsets.
  typedef enum logic [2:0] {
    REG_CTRL   = 3'd0,
    REG_DATA   = 3'd1,
    REG_STATUS = 3'd2,
    REG_WCNT   = 3'd3,
    REG_NONE   = 3'd4
  } apb_reg_e;

  // Full 12-bit compare, so any offset with PADDR[1:0]!=0 falls to REG_NONE.
  function automatic apb_reg_e decode_ofs(input logic [11:0] ofs);
    apb_reg_e r;
    case (ofs)
      OFS_CTRL:   r = REG_CTRL;
      OFS_DATA:   r = REG_DATA;
      OFS_STATUS: r = REG_STATUS;
      OFS_WCNT:   r = REG_WCNT;
      default:    r = REG_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/apb_slave_waitgen.sv
// Transfer FSM and wait-state counter: turns PSEL/PENABLE into a registered
// PREADY pulse and a commit strobe that marks the response cycle.
module apb_slave_waitgen
  import apb_slave_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic psel_i,
  input  logic penable_i,
  output logic ready_o,
  output logic commit_o
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  apb_slv_state_e state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           ready_q, ready_d;

  // Next-state logic: setup -> wait countdown -> single response cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // PSEL with PENABLE already high means the setup phase was missed.
        if (psel_i && !penable_i) begin
          state_d = WAIT;
          cnt_d   = WAIT_INIT;
        end
      end
      WAIT: begin
        if (!psel_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // PREADY is a flop loaded on entry to RESP, so it is high for exactly that cycle.
  always_comb begin
    ready_d = (state_d == RESP);
  end

  // State, counter and PREADY registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign ready_o  = ready_q;
  assign commit_o = ready_q;

endmodule

// File: rtl/apb_slave_regfile.sv
// APB responder with a 4-word register file (CTRL, DATA, STATUS, WCNT) and
// configurable wait states. Define APB_SLAVE_PSLVERR_EN to add the PSLVERR
// port and error responses for unmapped/unaligned offsets and STATUS writes.
module apb_slave_regfile
  import apb_slave_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] RESET_CTRL  = 32'h0000_0000
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic        PSEL,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
`ifdef APB_SLAVE_PSLVERR_EN
  output logic        PSLVERR,
`endif
  input  logic [31:0] status_i,
  output logic [31:0] ctrl_o,
  output logic [31:0] data_o,
  output logic        data_wr_o
);

  logic        ready;
  logic        commit;
  apb_reg_e    sel_reg;
  logic        wr_commit;
  logic [31:0] rd_mux;

  logic [31:0] ctrl_q, ctrl_d;
  logic [31:0] data_q, data_d;
  logic [31:0] wcnt_q, wcnt_d;
  logic        data_wr_q, data_wr_d;

  // Only the low 12 address bits are decoded.
  logic unused_paddr_hi;
  assign unused_paddr_hi = ^PADDR[31:12];

  apb_slave_waitgen #(
    .WAIT_STATES (WAIT_STATES)
  ) u_waitgen (
    .clk_i     (PCLK),
    .rst_ni    (PRESET),
    .psel_i    (PSEL),
    .penable_i (PENABLE),
    .ready_o   (ready),
    .commit_o  (commit)
  );

  assign sel_reg   = decode_ofs(PADDR[11:0]);
  assign wr_commit = commit && PSEL && PWRITE;

  // Register-file next state; address and data are taken from the response cycle.
  always_comb begin
    ctrl_d    = ctrl_q;
    data_d    = data_q;
    wcnt_d    = wcnt_q;
    data_wr_d = 1'b0;
    if (wr_commit) begin
      case (sel_reg)
        REG_CTRL: ctrl_d = PWDATA;
        REG_DATA: begin
          data_d    = PWDATA;
          wcnt_d    = wcnt_q + 32'd1;
          data_wr_d = 1'b1;
        end
        REG_WCNT: wcnt_d = '0;
        default:  ;
      endcase
    end
  end

  // Register-file state; a reset mid-transfer drops any write not yet committed.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      ctrl_q    <= RESET_CTRL;
      data_q    <= '0;
      wcnt_q    <= '0;
      data_wr_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      data_q    <= data_d;
      wcnt_q    <= wcnt_d;
      data_wr_q <= data_wr_d;
    end
  end

  // Read mux; STATUS is the live input as seen during the response cycle.
  always_comb begin
    case (sel_reg)
      REG_CTRL:   rd_mux = ctrl_q;
      REG_DATA:   rd_mux = data_q;
      REG_STATUS: rd_mux = status_i;
      REG_WCNT:   rd_mux = wcnt_q;
      default:    rd_mux = '0;
    endcase
  end

  // Read data is driven only in the response cycle of a read.
  always_comb begin
    PRDATA = (ready && !PWRITE) ? rd_mux : '0;
  end

`ifdef APB_SLAVE_PSLVERR_EN
  // Error response for unmapped/unaligned offsets and STATUS writes.
  always_comb begin
    PSLVERR = ready && ((sel_reg == REG_NONE) ||
                        ((sel_reg == REG_STATUS) && PWRITE));
  end
`endif

  assign PREADY    = ready;
  assign ctrl_o    = ctrl_q;
  assign data_o    = data_q;
  assign data_wr_o = data_wr_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench: three responders (WAIT_STATES 1, 4, 0) share the bus
// signals and have private PSEL lines.
module tb_apb_slave_regfile;

  localparam logic [31:0] RST_CTRL0 = 32'h1234_5678;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic        PENABLE;
  logic [31:0] PWDATA;
  logic [31:0] status;
  logic        psel    [3];
  logic [31:0] prdata_w[3];
  logic        ready_w [3];
  logic        err_w   [3];
  logic [31:0] ctrl_w  [3];
  logic [31:0] data_w  [3];
  logic        dwr_w   [3];

  int n_chk  = 0;
  int n_pass = 0;
  int dwr_cnt[3] = '{0, 0, 0};

  always #5 PCLK = ~PCLK;

  apb_slave_regfile #(.WAIT_STATES(1), .RESET_CTRL(RST_CTRL0)) dut0 (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWRITE(PWRITE),
    .PENABLE(PENABLE), .PSEL(psel[0]), .PWDATA(PWDATA), .PRDATA(prdata_w[0]),
    .PREADY(ready_w[0]),
`ifdef APB_SLAVE_PSLVERR_EN
    .PSLVERR(err_w[0]),
`endif
    .status_i(status), .ctrl_o(ctrl_w[0]), .data_o(data_w[0]), .data_wr_o(dwr_w[0]));

  apb_slave_regfile #(.WAIT_STATES(4), .RESET_CTRL(32'h0)) dut1 (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWRITE(PWRITE),
    .PENABLE(PENABLE), .PSEL(psel[1]), .PWDATA(PWDATA), .PRDATA(prdata_w[1]),
    .PREADY(ready_w[1]),
`ifdef APB_SLAVE_PSLVERR_EN
    .PSLVERR(err_w[1]),
`endif
    .status_i(status), .ctrl_o(ctrl_w[1]), .data_o(data_w[1]), .data_wr_o(dwr_w[1]));

  apb_slave_regfile #(.WAIT_STATES(0), .RESET_CTRL(32'h0)) dut2 (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWRITE(PWRITE),
    .PENABLE(PENABLE), .PSEL(psel[2]), .PWDATA(PWDATA), .PRDATA(prdata_w[2]),
    .PREADY(ready_w[2]),
`ifdef APB_SLAVE_PSLVERR_EN
    .PSLVERR(err_w[2]),
`endif
    .status_i(status), .ctrl_o(ctrl_w[2]), .data_o(data_w[2]), .data_wr_o(dwr_w[2]));

`ifndef APB_SLAVE_PSLVERR_EN
  initial begin
    for (int i = 0; i < 3; i++) err_w[i] = 1'b0;
  end
`endif

  // Count data_wr_o cycles per instance.
  always @(negedge PCLK) begin
    for (int i = 0; i < 3; i++) if (dwr_w[i] === 1'b1) dwr_cnt[i]++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  task automatic settle();
    @(negedge PCLK); #1;
  endtask

  // One complete transfer on instance d; lat = access cycle carrying PREADY (0 = timeout).
  task automatic xfer(input int d, input logic [31:0] addr, input logic wr,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output int lat, output logic err, output logic [31:0] hist);
    bit done;
    @(posedge PCLK); #1;
    psel[d] = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr; PWDATA = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    lat = 0; hist = '0; rdata = '0; err = 1'b0; done = 0;
    for (int k = 1; k <= 24 && !done; k++) begin
      @(negedge PCLK);
      if (ready_w[d] === 1'b1) begin
        hist[k] = 1'b1; lat = k; rdata = prdata_w[d]; err = err_w[d]; done = 1;
      end
      @(posedge PCLK); #1;
    end
    psel[d] = 1'b0; PENABLE = 1'b0;
  endtask

  logic [31:0] rd, hist;
  logic        er;
  int          lat;
  int          c0;
  bit          seen;

  initial begin
    PRESET = 1'b0; PADDR = '0; PWRITE = 1'b0; PENABLE = 1'b0; PWDATA = '0;
    status = '0;
    for (int i = 0; i < 3; i++) psel[i] = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    // Reset values while held in reset.
    check("rst_pready", 32'(ready_w[0]), 32'd0);
    check("rst_prdata", prdata_w[0], 32'd0);
    check("rst_ctrl", ctrl_w[0], RST_CTRL0);
    check("rst_data", data_w[0], 32'd0);
    check("rst_dwr", 32'(dwr_w[0]), 32'd0);
    PRESET = 1'b1;
    settle();
    check("rst_ctrl_after", ctrl_w[0], RST_CTRL0);
    xfer(0, 32'h00C, 1'b0, 32'h0, rd, lat, er, hist);
    check("rst_wcnt", rd, 32'd0);

    // DATA write with one wait state: PREADY on access cycle 3 only.
    xfer(0, 32'h004, 1'b1, 32'hDEAD_BEEF, rd, lat, er, hist);
    check("wr_hist", hist, 32'h0000_0008);
    check("wr_lat", 32'(lat), 32'd3);
    check("wr_prdata0", rd, 32'd0);
    settle();
    check("wr_data", data_w[0], 32'hDEAD_BEEF);
    check("wr_pulse", 32'(dwr_cnt[0]), 32'd1);
    settle();
    check("wr_pulse_once", 32'(dwr_cnt[0]), 32'd1);
    xfer(0, 32'h00C, 1'b0, 32'h0, rd, lat, er, hist);
    check("wcnt_1", rd, 32'd1);

    // STATUS read and ignored STATUS write.
    status = 32'h0000_00A5;
    xfer(0, 32'h008, 1'b0, 32'h0, rd, lat, er, hist);
    check("status_rd", rd, 32'h0000_00A5);
    check("status_rd_err", 32'(er), 32'd0);
    xfer(0, 32'h008, 1'b1, 32'hFFFF_FFFF, rd, lat, er, hist);
`ifdef APB_SLAVE_PSLVERR_EN
    check("status_wr_err", 32'(er), 32'd1);
`endif
    settle();
    check("status_wr_ctrl", ctrl_w[0], RST_CTRL0);
    check("status_wr_data", data_w[0], 32'hDEAD_BEEF);

    // CTRL write and readback.
    xfer(0, 32'h000, 1'b1, 32'hCAFE_F00D, rd, lat, er, hist);
    settle();
    check("ctrl_o", ctrl_w[0], 32'hCAFE_F00D);
    xfer(0, 32'h000, 1'b0, 32'h0, rd, lat, er, hist);
    check("ctrl_rd", rd, 32'hCAFE_F00D);

    // WCNT: clear, three DATA writes, read 3, clear, read 0.
    xfer(0, 32'h00C, 1'b1, 32'h1234, rd, lat, er, hist);
    c0 = dwr_cnt[0];
    xfer(0, 32'h004, 1'b1, 32'h1, rd, lat, er, hist);
    xfer(0, 32'h004, 1'b1, 32'h2, rd, lat, er, hist);
    xfer(0, 32'h004, 1'b1, 32'h3, rd, lat, er, hist);
    xfer(0, 32'h00C, 1'b0, 32'h0, rd, lat, er, hist);
    check("wcnt_3", rd, 32'd3);
    check("dwr_3", 32'(dwr_cnt[0] - c0), 32'd3);
    check("data_last", data_w[0], 32'h3);
    xfer(0, 32'h00C, 1'b1, 32'h0, rd, lat, er, hist);
    xfer(0, 32'h00C, 1'b0, 32'h0, rd, lat, er, hist);
    check("wcnt_0", rd, 32'd0);

    // Unaligned read returns 0; unaligned write ignored.
    xfer(0, 32'h005, 1'b0, 32'h0, rd, lat, er, hist);
    check("unal_rd", rd, 32'd0);
`ifdef APB_SLAVE_PSLVERR_EN
    check("unal_err", 32'(er), 32'd1);
`endif
    xfer(0, 32'h001, 1'b1, 32'h0BAD_0BAD, rd, lat, er, hist);
    settle();
    check("unal_wr_ctrl", ctrl_w[0], 32'hCAFE_F00D);

    // Missed setup phase: PSEL and PENABLE together from IDLE is ignored.
    @(posedge PCLK); #1;
    psel[0] = 1'b1; PENABLE = 1'b1; PADDR = 32'h000; PWRITE = 1'b1; PWDATA = 32'h5A5A_5A5A;
    seen = 0;
    repeat (6) begin @(negedge PCLK); if (ready_w[0] !== 1'b0) seen = 1; end
    @(posedge PCLK); #1;
    psel[0] = 1'b0; PENABLE = 1'b0;
    check("illegal_nordy", 32'(seen), 32'd0);
    settle();
    check("illegal_ctrl", ctrl_w[0], 32'hCAFE_F00D);

    // Abort during WAIT on the 4-wait-state instance.
    @(posedge PCLK); #1;
    psel[1] = 1'b1; PENABLE = 1'b0; PADDR = 32'h004; PWRITE = 1'b1; PWDATA = 32'hBAD0_BAD0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    repeat (2) @(posedge PCLK);
    #1;
    psel[1] = 1'b0; PENABLE = 1'b0;
    seen = 0;
    repeat (10) begin @(negedge PCLK); if (ready_w[1] !== 1'b0) seen = 1; end
    check("abort_nordy", 32'(seen), 32'd0);
    check("abort_data", data_w[1], 32'd0);
    check("abort_dwr", 32'(dwr_cnt[1]), 32'd0);
    xfer(1, 32'h004, 1'b1, 32'h0000_0055, rd, lat, er, hist);
    check("ws4_lat", 32'(lat), 32'd6);
    settle();
    check("ws4_data", data_w[1], 32'h0000_0055);
    check("ws4_dwr", 32'(dwr_cnt[1]), 32'd1);

    // Zero wait states: unmapped read completes on access cycle 2.
    xfer(2, 32'h010, 1'b0, 32'h0, rd, lat, er, hist);
    check("ws0_lat", 32'(lat), 32'd2);
    check("ws0_unmap_rd", rd, 32'd0);
`ifdef APB_SLAVE_PSLVERR_EN
    check("ws0_unmap_err", 32'(er), 32'd1);
`endif
    xfer(2, 32'h000, 1'b1, 32'h0F0F_0F0F, rd, lat, er, hist);
    xfer(2, 32'h000, 1'b0, 32'h0, rd, lat, er, hist);
    check("ws0_ctrl_rd", rd, 32'h0F0F_0F0F);

    // Reset in the middle of a DATA write discards it.
    c0 = dwr_cnt[0];
    @(posedge PCLK); #1;
    psel[0] = 1'b1; PENABLE = 1'b0; PADDR = 32'h004; PWRITE = 1'b1; PWDATA = 32'h7777_7777;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    #1;
    check("midrst_pready", 32'(ready_w[0]), 32'd0);
    check("midrst_ctrl", ctrl_w[0], RST_CTRL0);
    psel[0] = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    repeat (3) settle();
    check("midrst_data", data_w[0], 32'd0);
    check("midrst_dwr", 32'(dwr_cnt[0] - c0), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
